// File: rtl/poly_mod_mul_pipe.sv
// -----------------------------------------------------------------------------
// poly_mod_mul_pipe
//
// Three-stage pipelined modular multiplier for the fixed modulus q = 3329,
// producing o = (a*b) mod 3329 for the NTT butterfly twiddle product. The
// reduction uses Barrett's method with M = floor(2^26 / 3329) = 20158.
//
// The result feeds a combinational modular add/sub stage directly, so o is a
// clean register output in the range 0..3328.
//
// Flow control: a single global stall (out_valid & ~out_ready) freezes every
// stage at once. Throughput is one result per cycle, results leave in accept
// order and there is no internal buffering.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      a / b / in_tag valid this cycle
//   in_ready   out  1      stage accepts input this cycle (= ~stall)
//   a          in   WIDTH  operand, 0..4095
//   b          in   WIDTH  operand (twiddle), 0..4095
//   in_tag     in   TAG_W  sideband (coefficient index), passed through
//   out_valid  out  1      o / out_tag valid
//   out_ready  in   1      downstream accepts o this cycle
//   o          out  WIDTH  (a*b) mod 3329
//   out_tag    out  TAG_W  tag belonging to o
//
// Parameters
//   WIDTH  operand width; the Barrett constants are only valid for 12
//   TAG_W  sideband tag width
// -----------------------------------------------------------------------------
module poly_mod_mul_pipe #(
  parameter int WIDTH = 12,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic [TAG_W-1:0] out_tag
);

  localparam int          PW        = 2 * WIDTH;   // full product width (24)
  localparam int          QW        = 13;          // Barrett quotient width
  localparam int          RW        = 14;          // remainder working width
  localparam logic [14:0] BARRETT_M = 15'd20158;   // floor(2^26 / 3329)
  localparam logic [13:0] Q14       = 14'd3329;

  // Barrett quotient estimate t = (p * M) >> 26. For p < 2^24 it reaches
  // about 5037, so 13 bits are kept rather than 11; the low 14 bits of t*q
  // must be exact for the remainder to come out right.
  function automatic logic [QW-1:0] barrett_quot(input logic [PW-1:0] p);
    logic [PW+14:0] wide;
    wide = {15'd0, p} * {{PW{1'b0}}, BARRETT_M};
    return QW'(wide >> 26);
  endfunction

  // True remainder p - t*q lies in 0..2q-1 < 2^14, so modulo-2^14
  // arithmetic on the low bits of both terms is exact.
  function automatic logic [RW-1:0] barrett_rem(input logic [RW-1:0] p_lo,
                                                input logic [QW-1:0] t);
    return p_lo - RW'({1'b0, t} * Q14);
  endfunction

  // Barrett error is below 2, so a single conditional subtract of q
  // brings the remainder into 0..3328.
  function automatic logic [WIDTH-1:0] cond_sub_q(input logic [RW-1:0] r);
    logic [RW-1:0] s;
    s = (r >= Q14) ? (r - Q14) : r;
    return WIDTH'(s);
  endfunction

  // Global flow control: every stage advances together or not at all.
  logic stall;
  logic advance;

  // S1 registers: full product
  logic             vld_p1_q;
  logic [PW-1:0]    prod_p1_q;
  logic [PW-1:0]    prod_p1_d;
  logic [TAG_W-1:0] tag_p1_q;

  // S2 registers: low product bits and quotient estimate
  logic             vld_p2_q;
  logic [RW-1:0]    prod_lo_p2_q;
  logic [RW-1:0]    prod_lo_p2_d;
  logic [QW-1:0]    quot_p2_q;
  logic [QW-1:0]    quot_p2_d;
  logic [TAG_W-1:0] tag_p2_q;

  // S3 registers: reduced result (module outputs)
  logic             vld_p3_q;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_d;
  logic [TAG_W-1:0] out_tag_q;
  logic [RW-1:0]    rem_p3;

  assign stall    = vld_p3_q & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;

  assign out_valid = vld_p3_q;
  assign o         = o_q;
  assign out_tag   = out_tag_q;

  always_comb begin
    prod_p1_d    = PW'(a) * PW'(b);
    quot_p2_d    = barrett_quot(prod_p1_q);
    prod_lo_p2_d = prod_p1_q[RW-1:0];
    rem_p3       = barrett_rem(prod_lo_p2_q, quot_p2_q);
    o_d          = cond_sub_q(rem_p3);
  end

  // Valid bits: cleared by reset so in-flight items are dropped for good.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (advance) begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // ---- S0 -> S1 : multiply -------------------------------------------------
  always_ff @(posedge clk) begin
    if (advance) begin
      prod_p1_q <= prod_p1_d;
      tag_p1_q  <= in_tag;
    end
  end

  // ---- S1 -> S2 : Barrett quotient estimate --------------------------------
  always_ff @(posedge clk) begin
    if (advance) begin
      prod_lo_p2_q <= prod_lo_p2_d;
      quot_p2_q    <= quot_p2_d;
      tag_p2_q     <= tag_p2_d_sel(tag_p1_q);
    end
  end

  function automatic logic [TAG_W-1:0] tag_p2_d_sel(input logic [TAG_W-1:0] t);
    return t;
  endfunction

  // ---- S2 -> S3 : remainder, conditional subtract --------------------------
  // The output pair is only rewritten by a valid item, so o/out_tag keep the
  // last result through bubbles as well as through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q       <= '0;
      out_tag_q <= '0;
    end else if (advance && vld_p2_q) begin
      o_q       <= o_d;
      out_tag_q <= tag_p2_q;
    end
  end

endmodule

// File: tb/tb_poly_mod_mul_pipe.sv
module tb_poly_mod_mul_pipe;

  localparam int WIDTH = 12;
  localparam int TAG_W = 8;
  localparam int Q     = 3329;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic [TAG_W-1:0] out_tag;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] o;
  } exp_t;

  exp_t sb[$];

  poly_mod_mul_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    int unsigned p;
    p = 32'(x) * 32'(y);
    return WIDTH'(p % Q);
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [TAG_W-1:0] tv,
                       input logic ordy);
    in_valid  = v;
    a         = av;
    b         = bv;
    in_tag    = tv;
    out_ready = ordy;
  endtask

  task automatic push_expected();
    exp_t e;
    e.tag = in_tag;
    e.o   = model(a, b);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    checks++;
    if (o !== '0) begin
      failures++; $display("FAIL reset_o: got %0d, required 0", o);
    end
    checks++;
    if (out_tag !== '0) begin
      failures++; $display("FAIL reset_out_tag: got %h, required 00", out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    drive(1'b1, 12'd3328, 12'd3328, 8'h11, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL latency_early c=%0d: got out_valid=%b, required 0", c, out_valid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || o !== 12'd1 || out_tag !== 8'h11) begin
      failures++;
      $display("FAIL latency_result: got v=%b o=%0d tag=%h, required v=1 o=1 tag=11",
               out_valid, o, out_tag);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL latency_consumed: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_directed();
    int av [5] = '{4095, 1000, 0,    17,  3328};
    int bv [5] = '{4095, 2000, 1234, 17,  3328};
    int ev [5] = '{852,  2600, 0,    289, 1};
    exp_t e;
    for (int it = 0; it < 15; it++) begin
      if (it < 5) drive(1'b1, 12'(av[it]), 12'(bv[it]), 8'(8'h20 + it), 1'b1);
      else        drive(1'b0, '0, '0, '0, 1'b1);
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL directed_extra: got tag=%h o=%0d, required no output", out_tag, o);
        end else begin
          e = sb.pop_front();
          if (o !== e.o || out_tag !== e.tag) begin
            failures++;
            $display("FAIL directed_result: got tag=%h o=%0d, required tag=%h o=%0d",
                     out_tag, o, e.tag, e.o);
          end
        end
      end
      if (in_valid && !(out_valid === 1'b1 && !out_ready)) begin
        e.tag = in_tag;
        e.o   = 12'(ev[it]);
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL directed_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_stream();
    exp_t e;
    for (int it = 0; it < 264; it++) begin
      if (it < 256) drive(1'b1, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 8'(it), 1'b1);
      else          drive(1'b0, '0, '0, '0, 1'b1);
      #1;
      if (it >= 3 && it <= 258) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++; $display("FAIL stream_continuous it=%0d: got out_valid=%b, required 1", it, out_valid);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL stream_extra: got tag=%h o=%0d, required no output", out_tag, o);
        end else begin
          e = sb.pop_front();
          if (o !== e.o || out_tag !== e.tag) begin
            failures++;
            $display("FAIL stream_result: got tag=%h o=%0d, required tag=%h o=%0d",
                     out_tag, o, e.tag, e.o);
          end
        end
      end
      if (in_valid && !(out_valid === 1'b1 && !out_ready)) push_expected();
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL stream_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_random_stall();
    exp_t             e;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_o     = '0;
    logic [TAG_W-1:0] prev_tag   = '0;
    logic [TAG_W-1:0] tagc       = 8'h00;
    logic             exp_rdy;
    for (int it = 0; it < 1530; it++) begin
      if (it < 1500)
        drive(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
              12'($urandom_range(0, 4095)), tagc, 1'($urandom_range(0, 1)));
      else
        drive(1'b0, '0, '0, tagc, 1'b1);
      #1;
      exp_rdy = !(out_valid === 1'b1 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL stall_in_ready it=%0d: got %b, required %b", it, in_ready, exp_rdy);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || o !== prev_o || out_tag !== prev_tag) begin
          failures++;
          $display("FAIL stall_hold it=%0d: got v=%b o=%0d tag=%h, required v=1 o=%0d tag=%h",
                   it, out_valid, o, out_tag, prev_o, prev_tag);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL stall_extra: got tag=%h o=%0d, required no output", out_tag, o);
        end else begin
          e = sb.pop_front();
          if (o !== e.o || out_tag !== e.tag) begin
            failures++;
            $display("FAIL stall_result: got tag=%h o=%0d, required tag=%h o=%0d",
                     out_tag, o, e.tag, e.o);
          end
        end
      end
      if (in_valid && exp_rdy) begin
        push_expected();
        tagc = tagc + 8'd1;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_o     = o;
      prev_tag   = out_tag;
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL stall_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 8'(8'hA0 + k), 1'b1);
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b1);
    #1;
    checks++;
    if (out_valid !== 1'b0 || o !== '0 || out_tag !== '0) begin
      failures++;
      $display("FAIL flush_outputs: got v=%b o=%0d tag=%h, required v=0 o=0 tag=00",
               out_valid, o, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_in_ready: got %b, required 1", in_ready);
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_ghost c=%0d: got v=%b tag=%h, required v=0", c, out_valid, out_tag);
      end
    end
  endtask

  task automatic test_exhaustive();
    int               bset [6] = '{0, 1, 17, 1729, 3328, 4095};
    exp_t             e;
    logic [TAG_W-1:0] tagc = 8'h00;
    for (int bi = 0; bi <= 6; bi++) begin
      for (int ai = 0; ai < 4096; ai++) begin
        if (bi < 6) drive(1'b1, 12'(ai), 12'(bset[bi]), tagc, 1'b1);
        else        drive(1'b0, '0, '0, '0, 1'b1);
        #1;
        if (out_valid === 1'b1 && out_ready) begin
          checks++;
          if (o >= 12'd3329) begin
            failures++; $display("FAIL exh_range: got o=%0d, required below 3329", o);
          end
          checks++;
          if (sb.size() == 0) begin
            failures++; $display("FAIL exh_extra: got tag=%h o=%0d, required no output", out_tag, o);
          end else begin
            e = sb.pop_front();
            if (o !== e.o || out_tag !== e.tag) begin
              failures++;
              $display("FAIL exh_result: got tag=%h o=%0d, required tag=%h o=%0d",
                       out_tag, o, e.tag, e.o);
            end
          end
        end
        if (in_valid && !(out_valid === 1'b1 && !out_ready)) begin
          push_expected();
          tagc = tagc + 8'd1;
        end
        @(posedge clk); #1;
        if (bi == 6 && ai >= 8) break;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL exh_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_stream();
    test_random_stall();
    test_reset_flush();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
